two_min_finder: RTL

- Streaming stage that feeds the check-node min memory.
- For each of ROWS rows it accepts a stream of DW-bit magnitudes and tracks the smallest (min1) and second-smallest (min2) values.
- At the end of each row it presents min1/min2 with the row address for one cycle, with state = SORT, so the downstream memory writes them.
- After the last row it pulses done and returns to idle.

---
 rtl/two_min_finder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/two_min_finder.sv
// Per-row two-smallest tracker feeding the check-node min memory; one SORT cycle per row, done after the frame.
// Optional MIN_IDX_EN adds min1_idx, the in-row column of the sample currently holding mini1.
module two_min_finder #(
    parameter int DW   = 6,
    parameter int ROWS = 5,
    parameter int AW   = 3,
    parameter int IW   = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic          in_last,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [2:0]    state,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] mini1,
    output logic [DW-1:0] mini2,
    output logic          done
`ifdef MIN_IDX_EN
    ,
    output logic [IW-1:0] min1_idx
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SET  = 3'd2,
        S_SORT = 3'd3,
        S_DONE = 3'd4
    } st_t;

    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

    if ((1 << AW) < ROWS) begin : g_chk_aw
        $error("AW too narrow for ROWS");
    end
    if (IW < 1) begin : g_chk_iw
        $error("IW must be at least 1");
    end

    st_t           state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] m1_q, m1_d;
    logic [DW-1:0] m2_q, m2_d;
    logic          accept;

    assign accept = in_valid & in_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SET;
            S_SET:   if (accept && in_last) state_d = S_SORT;
            S_SORT:  state_d = (addr_q == LAST_ROW) ? S_DONE : S_SET;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: decoded outputs ----------------
    always_comb begin
        in_ready = (state_q == S_SET);
        done     = (state_q == S_DONE);
    end

    // ---------------- datapath ----------------
`ifdef MIN_IDX_EN
    logic [IW-1:0] col_q, col_d;
    logic [IW-1:0] idx_q, idx_d;
`endif

    always_comb begin
        addr_d = addr_q;
        m1_d   = m1_q;
        m2_d   = m2_q;
`ifdef MIN_IDX_EN
        col_d  = col_q;
        idx_d  = idx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d = '0;
                    m1_d   = '1;
                    m2_d   = '1;
`ifdef MIN_IDX_EN
                    col_d  = '0;
                    idx_d  = '0;
`endif
                end
            end
            S_SET: begin
                if (accept) begin
                    // A tie with mini1 is not smaller, so it lands in mini2 and the earlier index stays.
                    if (in_data < m1_q) begin
                        m2_d = m1_q;
                        m1_d = in_data;
`ifdef MIN_IDX_EN
                        idx_d = col_q;
`endif
                    end else if (in_data < m2_q) begin
                        m2_d = in_data;
                    end
`ifdef MIN_IDX_EN
                    col_d = col_q + IW'(1);
`endif
                end
            end
            S_SORT: begin
                if (addr_q != LAST_ROW) begin
                    addr_d = addr_q + AW'(1);
                    m1_d   = '1;
                    m2_d   = '1;
`ifdef MIN_IDX_EN
                    col_d  = '0;
                    idx_d  = '0;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            m1_q   <= '1;
            m2_q   <= '1;
        end else begin
            addr_q <= addr_d;
            m1_q   <= m1_d;
            m2_q   <= m2_d;
        end
    end

`ifdef MIN_IDX_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q <= '0;
            idx_q <= '0;
        end else begin
            col_q <= col_d;
            idx_q <= idx_d;
        end
    end
    assign min1_idx = idx_q;
`endif

    assign state = state_q;
    assign addr  = addr_q;
    assign mini1 = m1_q;
    assign mini2 = m2_q;

endmodule
